// File: rtl/phy_tx_fifo_2f_if.sv
// Byte/valid bus between the link layer and the PHY transmit FIFO.
// It also carries the occupancy flags the link layer uses for flow control.
interface phy_tx_fifo_2f_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
);
  logic [DATA_W-1:0] data_in;
  logic              push;
  logic              pause;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic              fifo_full;
  logic              fifo_empty;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   count;
  logic              overflow_err;

  modport master (
    output data_in, push, pause,
    input  data_out, valid_out, fifo_full, fifo_empty,
    input  almost_full, almost_empty, count, overflow_err
  );

  modport slave (
    input  data_in, push, pause,
    output data_out, valid_out, fifo_full, fifo_empty,
    output almost_full, almost_empty, count, overflow_err
  );
endinterface

// File: rtl/phy_tx_fifo_2f.sv
// Byte-wide transmit FIFO ahead of the 1x2 byte demux: absorbs link-layer bursts and
// emits a registered byte/valid stream at clk_2f, with occupancy flags and sticky overflow.
module phy_tx_fifo_2f #(
  parameter int                DATA_W    = 8,
  parameter int                ADDR_W    = 2,
  parameter int                AF_THRESH = 3,
  parameter int                AE_THRESH = 1,
  parameter logic [DATA_W-1:0] IDLE_SYM  = {DATA_W{1'b0}}
) (
  input  logic               clk_2f,
  input  logic               reset,
  phy_tx_fifo_2f_if.slave    bus
);
  localparam int              DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FULL_LVL = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] AF_LVL   = AF_THRESH[ADDR_W:0];
  localparam logic [ADDR_W:0] AE_LVL   = AE_THRESH[ADDR_W:0];

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wrPtr;
  logic [ADDR_W-1:0] rdPtr;
  logic [ADDR_W:0]   countReg;
  logic [DATA_W-1:0] dataOutReg;
  logic              validOutReg;
  logic              overflowReg;
  logic              fifoFull;
  logic              fifoEmpty;
  logic              popEn;
  logic              wrEn;

  assign fifoFull  = (countReg == FULL_LVL);
  assign fifoEmpty = (countReg == '0);
  assign popEn     = !fifoEmpty && !bus.pause;
  // A full FIFO still accepts a byte when a slot is freed on the same edge.
  assign wrEn      = bus.push && (!fifoFull || popEn);

  // Storage carries no reset so it maps onto plain RAM.
  always_ff @(posedge clk_2f) begin
    if (wrEn && !reset) begin
      mem[wrPtr] <= bus.data_in;
    end
  end

  always_ff @(posedge clk_2f) begin
    if (reset) begin
      wrPtr       <= '0;
      rdPtr       <= '0;
      countReg    <= '0;
      dataOutReg  <= IDLE_SYM;
      validOutReg <= 1'b0;
      overflowReg <= 1'b0;
    end else begin
      if (popEn) begin
        dataOutReg  <= mem[rdPtr];
        validOutReg <= 1'b1;
        rdPtr       <= rdPtr + 1'b1;
      end else begin
        dataOutReg  <= IDLE_SYM;
        validOutReg <= 1'b0;
      end
      if (wrEn) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (bus.push && !wrEn) begin
        overflowReg <= 1'b1;
      end
      case ({wrEn, popEn})
        2'b10:   countReg <= countReg + 1'b1;
        2'b01:   countReg <= countReg - 1'b1;
        default: countReg <= countReg;
      endcase
    end
  end

  assign bus.data_out     = dataOutReg;
  assign bus.valid_out    = validOutReg;
  assign bus.fifo_full    = fifoFull;
  assign bus.fifo_empty   = fifoEmpty;
  assign bus.almost_full  = (countReg >= AF_LVL);
  assign bus.almost_empty = (countReg <= AE_LVL);
  assign bus.count        = countReg;
  assign bus.overflow_err = overflowReg;
endmodule

// File: tb/tb_phy_tx_fifo_2f.sv
// Bench for phy_tx_fifo_2f: per-cycle vector table with hand-derived flags plus a
// byte scoreboard, and a hand-written continuous-stream sequence with demux lane split.
module tb_phy_tx_fifo_2f;
  localparam logic [7:0] IDLE = 8'h00;

  logic clk_2f = 1'b0;
  logic reset;
  always #5 clk_2f = ~clk_2f;

  phy_tx_fifo_2f_if #(.DATA_W(8), .ADDR_W(2)) bus ();

  phy_tx_fifo_2f #(
    .DATA_W(8), .ADDR_W(2), .AF_THRESH(3), .AE_THRESH(1), .IDLE_SYM(8'h00)
  ) dut (
    .clk_2f(clk_2f),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic       rst;
    logic       push;
    logic       pause;
    logic [7:0] din;
    logic       acc;
    logic       expValid;
    int         expCnt;
    logic       expOvf;
  } vecT;

  vecT        vecs[$];
  logic [7:0] sbq[$];
  logic [7:0] lane0Q[$];
  logic [7:0] lane1Q[$];
  bit         recordLanes = 1'b0;
  bit         laneSel = 1'b0;
  int         checks = 0;
  int         errors = 0;

  function automatic void addVec(input logic r, input logic p, input logic ps,
                                 input logic [7:0] d, input logic a,
                                 input logic ev, input int ec, input logic eo);
    vecT v;
    v.rst = r; v.push = p; v.pause = ps; v.din = d; v.acc = a;
    v.expValid = ev; v.expCnt = ec; v.expOvf = eo;
    vecs.push_back(v);
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Drive at the falling edge, let one rising edge pass, return at the next falling edge.
  task automatic step(input logic r, input logic p, input logic ps,
                      input logic [7:0] d, input logic a);
    reset = r; bus.push = p; bus.pause = ps; bus.data_in = d;
    if (r) sbq.delete();
    else if (p && a) sbq.push_back(d);
    @(posedge clk_2f);
    @(negedge clk_2f);
  endtask

  task automatic checkOut(input string tag, input logic ev, input int ec, input logic eo);
    logic [7:0] want;
    cmp({tag, ":valid"}, 32'(bus.valid_out), 32'(ev));
    cmp({tag, ":count"}, 32'(bus.count), 32'(ec));
    cmp({tag, ":full"}, 32'(bus.fifo_full), 32'(ec == 4));
    cmp({tag, ":empty"}, 32'(bus.fifo_empty), 32'(ec == 0));
    cmp({tag, ":afull"}, 32'(bus.almost_full), 32'(ec >= 3));
    cmp({tag, ":aempty"}, 32'(bus.almost_empty), 32'(ec <= 1));
    cmp({tag, ":ovf"}, 32'(bus.overflow_err), 32'(eo));
    if (bus.valid_out === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s:sb_empty actual=%0h required=no_output", tag, bus.data_out);
      end else begin
        want = sbq.pop_front();
        cmp({tag, ":data"}, 32'(bus.data_out), 32'(want));
        $display("tx %s byte=%02h count=%0d", tag, bus.data_out, bus.count);
        if (recordLanes) begin
          if (laneSel) lane1Q.push_back(bus.data_out);
          else         lane0Q.push_back(bus.data_out);
          laneSel = ~laneSel;
        end
      end
    end else begin
      cmp({tag, ":idle"}, 32'(bus.data_out), 32'(IDLE));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; bus.push = 1'b0; bus.pause = 1'b0; bus.data_in = 8'h00;

    // rst push pause din acc | valid count ovf
    addVec(1, 0, 0, 8'h00, 0, 0, 0, 0);
    addVec(1, 0, 0, 8'h00, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) addVec(0, 0, 0, 8'h00, 0, 0, 0, 0);
    // single byte, two-edge latency
    addVec(0, 1, 0, 8'hBC, 1, 0, 1, 0);
    addVec(0, 0, 0, 8'h00, 0, 1, 0, 0);
    addVec(0, 0, 0, 8'h00, 0, 0, 0, 0);
    // fill while paused, overflow on fifth push, then drain
    for (int i = 1; i <= 4; i++) addVec(0, 1, 1, 8'(i), 1, 0, i, 0);
    addVec(0, 1, 1, 8'h05, 0, 0, 4, 1);
    addVec(0, 0, 0, 8'h00, 0, 1, 3, 1);
    addVec(0, 0, 0, 8'h00, 0, 1, 2, 1);
    addVec(0, 0, 0, 8'h00, 0, 1, 1, 1);
    addVec(0, 0, 0, 8'h00, 0, 1, 0, 1);
    addVec(0, 0, 0, 8'h00, 0, 0, 0, 1);
    addVec(1, 0, 0, 8'h00, 0, 0, 0, 0);
    // full FIFO: simultaneous push and pop is not an overflow
    for (int i = 0; i < 4; i++) addVec(0, 1, 1, 8'(8'hA0 + i), 1, 0, i + 1, 0);
    addVec(0, 1, 0, 8'hAA, 1, 1, 4, 0);
    addVec(0, 0, 0, 8'h00, 0, 1, 3, 0);
    addVec(0, 0, 0, 8'h00, 0, 1, 2, 0);
    addVec(0, 0, 0, 8'h00, 0, 1, 1, 0);
    addVec(0, 0, 0, 8'h00, 0, 1, 0, 0);
    addVec(0, 0, 0, 8'h00, 0, 0, 0, 0);
    // pause mid-stream drops valid on the next edge
    addVec(0, 1, 0, 8'hB0, 1, 0, 1, 0);
    addVec(0, 1, 0, 8'hB1, 1, 1, 1, 0);
    addVec(0, 0, 1, 8'h00, 0, 0, 1, 0);
    addVec(0, 0, 0, 8'h00, 0, 1, 0, 0);
    addVec(0, 0, 0, 8'h00, 0, 0, 0, 0);
    // reset with count = 3 and a coincident push
    addVec(0, 1, 1, 8'hC0, 1, 0, 1, 0);
    addVec(0, 1, 1, 8'hC1, 1, 0, 2, 0);
    addVec(0, 1, 1, 8'hC2, 1, 0, 3, 0);
    addVec(1, 1, 0, 8'hC3, 0, 0, 0, 0);
    addVec(0, 0, 0, 8'h00, 0, 0, 0, 0);
    addVec(0, 1, 0, 8'hD0, 1, 0, 1, 0);
    addVec(0, 0, 0, 8'h00, 0, 1, 0, 0);
    addVec(0, 0, 0, 8'h00, 0, 0, 0, 0);
    // reset while bytes are streaming out
    addVec(0, 1, 0, 8'hE0, 1, 0, 1, 0);
    addVec(0, 1, 0, 8'hE1, 1, 1, 1, 0);
    addVec(0, 1, 0, 8'hE2, 1, 1, 1, 0);
    addVec(1, 0, 0, 8'h00, 0, 0, 0, 0);
    addVec(0, 0, 0, 8'h00, 0, 0, 0, 0);

    @(negedge clk_2f);
    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].push, vecs[i].pause, vecs[i].din, vecs[i].acc);
      checkOut($sformatf("v%0d", i), vecs[i].expValid, vecs[i].expCnt, vecs[i].expOvf);
    end

    // Continuous stream: one byte per cycle, occupancy stays at 1.
    recordLanes = 1'b1;
    laneSel = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 0, 8'(8'h10 + i), 1);
      checkOut($sformatf("s%0d", i), i > 0, 1, 0);
    end
    step(0, 0, 0, 8'h00, 0);
    checkOut("s16", 1, 0, 0);
    recordLanes = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 8'h00, 0);
      checkOut($sformatf("d%0d", i), 0, 0, 0);
    end

    // Demux alternates lanes starting at lane 0.
    cmp("lane0_len", 32'(lane0Q.size()), 32'd8);
    cmp("lane1_len", 32'(lane1Q.size()), 32'd8);
    if (lane0Q.size() == 8 && lane1Q.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        cmp($sformatf("lane0_%0d", i), 32'(lane0Q[i]), 32'(8'h10 + 2 * i));
        cmp($sformatf("lane1_%0d", i), 32'(lane1Q[i]), 32'(8'h11 + 2 * i));
      end
    end
    cmp("sb_drained", 32'(sbq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/phy_tx_fifo_2f.md
Name: phy_tx_fifo_2f

Overview:
Byte-wide transmit FIFO that sits directly upstream of the 1x2 byte demux in the PHY transmit path. It absorbs bursty bytes from the link layer and issues a steady byte/valid stream at clk_2f into the demux's data and valid inputs. It provides occupancy flags for upstream flow control and a downstream pause input. A sticky overflow error flag reports dropped writes.

Parameters:
DATA_W, 8, byte width of data path.
ADDR_W, 2, pointer width; DEPTH = 2**ADDR_W entries (default 4).
AF_THRESH, 3, almost_full asserts when count >= AF_THRESH.
AE_THRESH, 1, almost_empty asserts when count <= AE_THRESH.
IDLE_SYM, 8'h00, value driven on data_out whenever valid_out = 0.

Ports:
clk_2f  input  1  clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
data_in  input  DATA_W  byte from link layer.
push  input  1  write strobe; data_in is sampled when push = 1.
pause  input  1  downstream hold; blocks pops while high.
data_out  output  DATA_W  registered byte to demux data input.
valid_out  output  1  registered; qualifies data_out, drives demux valid input.
fifo_full  output  1  count == DEPTH.
fifo_empty  output  1  count == 0.
almost_full  output  1  count >= AF_THRESH.
almost_empty  output  1  count <= AE_THRESH.
count  output  ADDR_W+1  current occupancy, 0..DEPTH.
overflow_err  output  1  sticky; set on a dropped push.

Behaviour:
- Reset (synchronous, active-high, clock clk_2f):
  - wr_ptr, rd_ptr and count go to 0.
  - data_out = IDLE_SYM, valid_out = 0, overflow_err = 0.
  - Flags follow count: fifo_empty = 1, almost_empty = 1, fifo_full = 0, almost_full = 0 (for AF_THRESH >= 1).
  - Reset mid-operation flushes all stored bytes. A push or pop in the same cycle as reset is ignored.
  - Memory contents need no reset.
- Flags are combinational from the registered count.
- pop_en = !fifo_empty && !pause, evaluated on pre-edge state.
- wr_en = push && (!fifo_full || pop_en):
  - Writing into a full FIFO is allowed when a pop occurs in the same cycle.
- Pop cycle (pop_en = 1): data_out <= mem[rd_ptr], valid_out <= 1, rd_ptr increments.
- Non-pop cycle: data_out <= IDLE_SYM, valid_out <= 0.
- Write cycle: mem[wr_ptr] <= data_in, wr_ptr increments.
- Pointers wrap modulo DEPTH; no extra wrap bit is needed because count is explicit.
- count update: +1 on write only, -1 on pop only, unchanged when both or neither occur.
- Latency:
  - push sampled at edge k into an empty FIFO with pause = 0 -> count = 1 after edge k.
  - data_out = that byte, valid_out = 1 after edge k+1 (2-edge latency).
  - Write-through bypass is not permitted.
- Throughput: with continuous push and pause = 0, one byte per clk_2f cycle; count settles at 1.
- Overflow: push = 1 while fifo_full = 1 and pop_en = 0 -> byte dropped, count and pointers unchanged, overflow_err <= 1 and held until reset.
- Pop from an empty FIFO never occurs; no underflow state exists.
- pause = 1: contents are held and writes continue; valid_out drops at the next edge.
- Order is strict FIFO. No reordering or duplication is allowed.

Test Plan:
1. Reset then idle, pause = 0 -> data_out = 8'h00, valid_out = 0, fifo_empty = 1, count = 0, overflow_err = 0 for 10 cycles.
2. Single push of 8'hBC at edge k -> count = 1 after k; data_out = 8'hBC, valid_out = 1 after k+1; then valid_out = 0, fifo_empty = 1.
3. pause = 1, push 8'h01..8'h04 over 4 cycles -> count = 4, fifo_full = 1, almost_full = 1 from count 3. Fifth push of 8'h05 -> dropped, overflow_err = 1. Release pause -> output 01,02,03,04 on consecutive cycles, never 05.
4. FIFO full (pause = 0 at release) with simultaneous push of 8'hAA and pop -> count stays 4, overflow_err stays 0, 8'hAA emerges after the four earlier bytes.
5. Continuous push 8'h10..8'h1F with pause = 0 -> 16 consecutive valid bytes in order, count never exceeds 1; check demux lane split downstream.
6. Reset asserted with count = 3 mid-stream -> next cycle count = 0, valid_out = 0, data_out = 8'h00. A push coincident with reset is not stored.
